// File: rtl/vga_timing_pkg.sv
// Shared raster timing constants, default counter width and the sync/blank bundle type.
// Pure definitions with no logic, latency or flow control of its own.
package vga_timing_pkg;

  localparam int DEFAULT_CW     = 11;
  localparam int MAX_PIPE_DELAY = 15;

  // 640x480 @ 60 Hz
  localparam int VGA640_H_ACTIVE = 640;
  localparam int VGA640_H_FP     = 16;
  localparam int VGA640_H_SYNC   = 96;
  localparam int VGA640_H_BP     = 48;
  localparam int VGA640_V_ACTIVE = 480;
  localparam int VGA640_V_FP     = 10;
  localparam int VGA640_V_SYNC   = 2;
  localparam int VGA640_V_BP     = 33;

  // 1024x768 @ 60 Hz
  localparam int XGA1024_H_ACTIVE = 1024;
  localparam int XGA1024_H_FP     = 24;
  localparam int XGA1024_H_SYNC   = 136;
  localparam int XGA1024_H_BP     = 160;
  localparam int XGA1024_V_ACTIVE = 768;
  localparam int XGA1024_V_FP     = 3;
  localparam int XGA1024_V_SYNC   = 6;
  localparam int XGA1024_V_BP     = 29;

  typedef struct packed {
    logic hs;
    logic vs;
    logic blank;
  } sync_bus_t;

  function automatic logic in_window(input int pos, input int beg, input int len);
    return (pos >= beg) && (pos < beg + len);
  endfunction

endpackage

// File: rtl/vga_timing_gen_sync_delay_line.sv
// Enable-gated shift register, DEPTH enabled steps of latency (DEPTH=0 is a wire).
// Holds its contents whenever en_i is low; synchronous reset loads rst_val_i into every stage.
module sync_delay_line #(
  parameter int W     = 3,
  parameter int DEPTH = 0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  input  logic [W-1:0] rst_val_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  if (DEPTH == 0) begin : g_bypass
    logic unused_ctrl;
    assign unused_ctrl = ^{clk_i, rst_i, en_i, rst_val_i};
    assign q_o         = d_i;
  end else begin : g_pipe
    logic [W-1:0] stage_q [DEPTH];

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        for (int i = 0; i < DEPTH; i++) stage_q[i] <= rst_val_i;
      end else if (en_i) begin
        stage_q[0] <= d_i;
        for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
      end
    end

    assign q_o = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster counters with registered sync/blank aligned to hcount/vcount (zero latency), advancing only on pix_en.
// *_d outputs lag by PIPE_DELAY enabled steps; pix_en low freezes all state, reset overrides pix_en.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   H_ACTIVE    = VGA640_H_ACTIVE,
  parameter int   H_FP        = VGA640_H_FP,
  parameter int   H_SYNC      = VGA640_H_SYNC,
  parameter int   H_BP        = VGA640_H_BP,
  parameter int   V_ACTIVE    = VGA640_V_ACTIVE,
  parameter int   V_FP        = VGA640_V_FP,
  parameter int   V_SYNC      = VGA640_V_SYNC,
  parameter int   V_BP        = VGA640_V_BP,
  parameter logic SYNC_ACTIVE = 1'b0,
  parameter int   CW          = DEFAULT_CW,
  parameter int   PIPE_DELAY  = 0
) (
  input  logic          vga_clock,
  input  logic          reset,
  input  logic          pix_en,
  output logic [CW-1:0] hcount,
  output logic [CW-1:0] vcount,
  output logic          hsync,
  output logic          vsync,
  output logic          blank,
  output logic          at_display_area,
  output logic          line_start,
  output logic          frame_start,
  output logic          hsync_d,
  output logic          vsync_d,
  output logic          blank_d
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_LAST    = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST    = CW'(V_TOTAL - 1);
  localparam logic          SYNC_IDLE = ~SYNC_ACTIVE;
  localparam sync_bus_t     DLY_RST   = '{hs: SYNC_IDLE, vs: SYNC_IDLE, blank: 1'b1};

  if (H_TOTAL > (1 << CW)) begin : g_bad_h_total
    $error("vga_timing_gen: H_TOTAL does not fit in CW bits");
  end
  if (V_TOTAL > (1 << CW)) begin : g_bad_v_total
    $error("vga_timing_gen: V_TOTAL does not fit in CW bits");
  end
  if (PIPE_DELAY < 0 || PIPE_DELAY > MAX_PIPE_DELAY) begin : g_bad_delay
    $error("vga_timing_gen: PIPE_DELAY out of range");
  end

  logic [CW-1:0] hcnt_q, hcnt_d;
  logic [CW-1:0] vcnt_q, vcnt_d;
  logic          hs_q, hs_d;
  logic          vs_q, vs_d;
  logic          bl_q, bl_d;

  // Sync/blank are derived from the next counter values so the registers line up with the counters.
  always_comb begin
    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;
    if (pix_en) begin
      if (hcnt_q == H_LAST) begin
        hcnt_d = '0;
        vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + CW'(1);
      end else begin
        hcnt_d = hcnt_q + CW'(1);
      end
    end
    hs_d = in_window(int'(hcnt_d), H_ACTIVE + H_FP, H_SYNC) ? SYNC_ACTIVE : SYNC_IDLE;
    vs_d = in_window(int'(vcnt_d), V_ACTIVE + V_FP, V_SYNC) ? SYNC_ACTIVE : SYNC_IDLE;
    bl_d = (int'(hcnt_d) >= H_ACTIVE) || (int'(vcnt_d) >= V_ACTIVE);
  end

  always_ff @(posedge vga_clock) begin
    if (reset) begin
      hcnt_q <= '0;
      vcnt_q <= '0;
      hs_q   <= SYNC_IDLE;
      vs_q   <= SYNC_IDLE;
      bl_q   <= 1'b0;
    end else if (pix_en) begin
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
      hs_q   <= hs_d;
      vs_q   <= vs_d;
      bl_q   <= bl_d;
    end
  end

  assign hcount          = hcnt_q;
  assign vcount          = vcnt_q;
  assign hsync           = hs_q;
  assign vsync           = vs_q;
  assign blank           = bl_q;
  assign at_display_area = ~bl_q;
  assign line_start      = pix_en && (hcnt_q == '0);
  assign frame_start     = line_start && (vcnt_q == '0);

  sync_bus_t cur_bus, dly_bus;
  assign cur_bus = '{hs: hs_q, vs: vs_q, blank: bl_q};

  sync_delay_line #(
    .W    ($bits(sync_bus_t)),
    .DEPTH(PIPE_DELAY)
  ) u_sync_delay (
    .clk_i    (vga_clock),
    .rst_i    (reset),
    .en_i     (pix_en),
    .rst_val_i(DLY_RST),
    .d_i      (cur_bus),
    .q_o      (dly_bus)
  );

  assign hsync_d = dly_bus.hs;
  assign vsync_d = dly_bus.vs;
  assign blank_d = dly_bus.blank;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Drives three generator configurations from one clock/reset/pix_en and compares every output, every clock,
// against a position-based raster model (pixel step index -> h, v, sync windows, delayed copies).
module tb_vga_timing_gen;
  import vga_timing_pkg::*;

  typedef struct {
    int ha, hf, hs, hb, va, vf, vs, vb;
    bit sa;
    int d;
  } tim_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic pix_en;
  int   checks = 0;
  int   errors = 0;
  int   pos    = 0;
  int   cyc    = 0;
  int   mult   = 0;
  int   last_ls0, last_ls2, last_fs1;

  tim_t t0, t1, t2;

  wire [10:0] h0, v0, h2, v2;
  wire [4:0]  h1, v1;
  wire [8:0]  f0, f1, f2;

  vga_timing_gen u_def (
    .vga_clock(clk), .reset(rst), .pix_en(pix_en), .hcount(h0), .vcount(v0),
    .hsync(f0[8]), .vsync(f0[7]), .blank(f0[6]), .at_display_area(f0[5]),
    .line_start(f0[4]), .frame_start(f0[3]), .hsync_d(f0[2]), .vsync_d(f0[1]), .blank_d(f0[0])
  );

  vga_timing_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .SYNC_ACTIVE(1'b0), .CW(5), .PIPE_DELAY(3)
  ) u_small (
    .vga_clock(clk), .reset(rst), .pix_en(pix_en), .hcount(h1), .vcount(v1),
    .hsync(f1[8]), .vsync(f1[7]), .blank(f1[6]), .at_display_area(f1[5]),
    .line_start(f1[4]), .frame_start(f1[3]), .hsync_d(f1[2]), .vsync_d(f1[1]), .blank_d(f1[0])
  );

  vga_timing_gen #(
    .H_ACTIVE(XGA1024_H_ACTIVE), .H_FP(XGA1024_H_FP), .H_SYNC(XGA1024_H_SYNC), .H_BP(XGA1024_H_BP),
    .V_ACTIVE(XGA1024_V_ACTIVE), .V_FP(XGA1024_V_FP), .V_SYNC(XGA1024_V_SYNC), .V_BP(XGA1024_V_BP),
    .SYNC_ACTIVE(1'b1), .CW(11), .PIPE_DELAY(2)
  ) u_xga (
    .vga_clock(clk), .reset(rst), .pix_en(pix_en), .hcount(h2), .vcount(v2),
    .hsync(f2[8]), .vsync(f2[7]), .blank(f2[6]), .at_display_area(f2[5]),
    .line_start(f2[4]), .frame_start(f2[3]), .hsync_d(f2[2]), .vsync_d(f2[1]), .blank_d(f2[0])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (pos %0d, cycle %0d)", tag, got, exp, pos, cyc);
    end
  endtask

  function automatic int htot(input tim_t t);
    return t.ha + t.hf + t.hs + t.hb;
  endfunction

  function automatic int vtot(input tim_t t);
    return t.va + t.vf + t.vs + t.vb;
  endfunction

  // Raster state after q enabled steps since reset.
  function automatic void raster(input tim_t t, input int q, output int h, output int v,
                                 output logic hs, output logic vs, output logic bl);
    h  = q % htot(t);
    v  = (q / htot(t)) % vtot(t);
    hs = (h >= t.ha + t.hf && h < t.ha + t.hf + t.hs) ? t.sa : ~t.sa;
    vs = (v >= t.va + t.vf && v < t.va + t.vf + t.vs) ? t.sa : ~t.sa;
    bl = (h >= t.ha) || (v >= t.va);
  endfunction

  function automatic logic [8:0] exp_flags(input tim_t t, input int p, input logic en,
                                           output int h, output int v);
    logic hs, vs, bl, hsd, vsd, bld;
    int   hq, vq;
    raster(t, p, h, v, hs, vs, bl);
    if (p >= t.d) begin
      raster(t, p - t.d, hq, vq, hsd, vsd, bld);
    end else begin
      hsd = ~t.sa;
      vsd = ~t.sa;
      bld = 1'b1;
    end
    return {hs, vs, bl, ~bl, en && (h == 0), en && (h == 0) && (v == 0), hsd, vsd, bld};
  endfunction

  task automatic check_all();
    logic [8:0] e;
    int eh, ev;
    e = exp_flags(t0, pos, pix_en, eh, ev);
    check("def_hcount", 32'(h0), eh);
    check("def_vcount", 32'(v0), ev);
    check("def_flags", 32'(f0), 32'(e));
    e = exp_flags(t1, pos, pix_en, eh, ev);
    check("small_hcount", 32'(h1), eh);
    check("small_vcount", 32'(v1), ev);
    check("small_flags", 32'(f1), 32'(e));
    e = exp_flags(t2, pos, pix_en, eh, ev);
    check("xga_hcount", 32'(h2), eh);
    check("xga_vcount", 32'(v2), ev);
    check("xga_flags", 32'(f2), 32'(e));
    if (mult > 0) begin
      if (f0[4]) begin
        if (last_ls0 >= 0) check("def_line_period", cyc - last_ls0, htot(t0) * mult);
        last_ls0 = cyc;
      end
      if (f2[4]) begin
        if (last_ls2 >= 0) check("xga_line_period", cyc - last_ls2, htot(t2) * mult);
        last_ls2 = cyc;
      end
      if (f1[3]) begin
        if (last_fs1 >= 0) check("small_frame_period", cyc - last_fs1, htot(t1) * vtot(t1) * mult);
        last_fs1 = cyc;
      end
    end
  endtask

  // Inputs change at the falling edge; outputs are checked 1 ns later, then the rising edge advances the model.
  task automatic step(input logic r, input logic en);
    rst    = r;
    pix_en = en;
    #1;
    check_all();
    @(posedge clk);
    cyc++;
    if (r) begin
      pos      = 0;
      last_ls0 = -1;
      last_ls2 = -1;
      last_fs1 = -1;
    end else if (en) begin
      pos++;
    end
    @(negedge clk);
  endtask

  initial begin
    t0 = '{VGA640_H_ACTIVE, VGA640_H_FP, VGA640_H_SYNC, VGA640_H_BP,
           VGA640_V_ACTIVE, VGA640_V_FP, VGA640_V_SYNC, VGA640_V_BP, 1'b0, 0};
    t1 = '{16, 2, 3, 3, 8, 1, 2, 2, 1'b0, 3};
    t2 = '{XGA1024_H_ACTIVE, XGA1024_H_FP, XGA1024_H_SYNC, XGA1024_H_BP,
           XGA1024_V_ACTIVE, XGA1024_V_FP, XGA1024_V_SYNC, XGA1024_V_BP, 1'b1, 2};
    last_ls0 = -1;
    last_ls2 = -1;
    last_fs1 = -1;
    rst      = 1'b1;
    pix_en   = 1'b0;
    @(negedge clk);

    // The first real comparisons come from the first step after the initial reset edge.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);

    // Clock-per-pixel: several 640 lines, two 1344 lines, many small frames.
    mult = 1;
    for (int i = 0; i < 2800; i++) step(1'b0, 1'b1);

    // One enabled clock in four.
    mult = 4;
    step(1'b1, 1'b0);
    for (int i = 0; i < 6600; i++) step(1'b0, (i % 4) == 0);

    // Reset arrives mid-line with pix_en high, then counting restarts from (0,0).
    mult = 0;
    step(1'b1, 1'b1);
    for (int i = 0; i < 2 * 800 + 700; i++) step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    for (int i = 0; i < 400; i++) step(1'b0, 1'b1);

    // Random enable pattern with occasional resets.
    for (int i = 0; i < 8000; i++) step($urandom_range(0, 499) == 0, $urandom_range(0, 3) != 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
